seg14_letter_decoder: RTL and testbench
=======================================

# seg14_letter_decoder

Recovers the 5-bit letter code (A=0 … Z=25) from a 14-segment display pattern; it is the inverse of the alphabet-to-segment decoder. Segment samples arrive on a valid/ready stream. A pattern must hold stable for a programmable number of accepted beats before it is decoded. Decoding is a sequential search of the shared letter table, and the result leaves on a second valid/ready stream. The block sits on the display-readback path, for self-check and loopback of the LED display.

## Interface
- STABLE_CYCLES, default 4: number of consecutive identical accepted beats required before decode; legal range 1–15.
- CNT_W, default 4: width of the stability counter; must hold STABLE_CYCLES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- seg_i  in  14  segment pattern, bit n = segment s[n].
- seg_valid_i  in  1  seg_i is valid this cycle.
- seg_ready_o  out  1  block accepts seg_i; a beat is accepted when valid and ready are both high.
- code_o  out  5  decoded letter index 0–25, or 5'h1F for blank or no match.
- err_o  out  1  high with code_o when the pattern matched no letter.
- code_valid_o  out  1  code_o and err_o are valid.
- code_ready_i  in  1  downstream accepts the result.

## Operation
- FSM states: IDLE, SETTLE, SCAN, OUT. The reset state is IDLE.
- **IDLE**
  - seg_ready_o=1.
  - An accepted beat loads cap←seg_i and cnt←1.
  - Next state is SCAN if STABLE_CYCLES==1; otherwise SETTLE.
- **SETTLE**
  - seg_ready_o=1.
  - Accepted beat equal to cap: cnt←cnt+1.
  - Accepted beat not equal to cap: cap←seg_i, cnt←1.
  - No beat accepted: cnt holds. Gaps do not break stability.
  - When an equal beat makes cnt reach STABLE_CYCLES:
    - cap==0: next state is OUT with code=5'h1F, err=0. Blank display, no scan.
    - otherwise: next state is SCAN with idx←0.
- **SCAN**
  - seg_ready_o=0.
  - Each cycle compares cap with SEG_TABLE[idx].
  - Match: code←idx, err←0, next state OUT.
  - No match with idx==25: code←5'h1F, err←1, next state OUT.
  - Otherwise idx←idx+1.
  - The first match wins. The table guarantees unique entries.
- **OUT**
  - seg_ready_o=0, code_valid_o=1.
  - code_o and err_o are stable until the handshake.
  - On code_ready_i=1: next state IDLE, code_valid_o falls next cycle.
- Outputs code_o and err_o are registered. They keep their last value outside OUT but are only meaningful while code_valid_o=1.
- Reset values: code_o=0, err_o=0, code_valid_o=0, cnt=0, idx=0, cap=0, state IDLE (so seg_ready_o=1).
- Reset mid-operation: asynchronous clear of all state. Any pending result is discarded and no partial handshake completes.
- Input sampled while seg_ready_o=0 is ignored and not buffered. The upstream must hold valid.

## Timing
- Reference point: first accepted beat at cycle t, then identical beats every cycle, STABLE_CYCLES=N≥2.
- cnt reaches N at the edge ending cycle t+N−1, so the block is in SCAN at cycle t+N.
- Hit on letter k: code_valid_o first high at cycle t+N+k+1 (A at t+N+1, Z at t+N+26).
- Miss: code_valid_o at cycle t+N+26, with err_o=1.
- Blank: code_valid_o at cycle t+N.
- N=1: block is in SCAN at t+1, hit k → valid at t+k+2.
- Result handshake at cycle u: seg_ready_o=1 at cycle u+1. Throughput is one result per full decode.
- code_valid_o high with code_ready_i low: the result holds indefinitely.

## Structure
- Shared package alpha14_pkg:
  - LETTER_COUNT=26, CODE_BLANK=5'h1F.
  - SEG_TABLE[0:25] of 14-bit patterns. It is the same table the alphabet-to-segment decoder uses and is the single source of truth.
  - The FSM state enum.
- Sub-module seg14_table_rom: combinational idx[4:0] → pattern[13:0]. Indices ≥26 return 0. It is shared with the encoder side.

## Test plan
- N=4, SEG_TABLE[0] for 4 back-to-back beats from t → code_o=0, err_o=0, code_valid_o rises at t+5.
- N=4, SEG_TABLE[25] for 4 beats → code_o=25 at t+30. Holding code_ready_i=0 for 10 cycles keeps code_o=25 and seg_ready_o=0.
- N=4, 14'h3FFF (absent from the table) → code_o=5'h1F, err_o=1 at t+30.
- N=4, pattern 0 for 4 beats → code_o=5'h1F, err_o=0 at t+4.
- N=4, SEG_TABLE[2] ×3 then SEG_TABLE[7] ×4 with 2 idle gaps → decodes code_o=7 only. The counter restarts on the change and holds across the gaps.
- Assert rst_n low during SCAN, then release → code_valid_o=0 immediately, seg_ready_o=1, and a fresh SEG_TABLE[4] sequence then decodes to 4.

Source files
------------

// File: rtl/alpha14_pkg.sv
// Shared 14-segment alphabet definitions: letter table, result payload and
// decoder FSM states, used by both the encoder and decoder sides.
package alpha14_pkg;

  localparam int unsigned SEG_W        = 14;
  localparam int unsigned CODE_W       = 5;
  localparam int unsigned LETTER_COUNT = 26;

  localparam logic [CODE_W-1:0] CODE_BLANK = 5'h1F;

  typedef logic [SEG_W-1:0] seg_t;

  // Bit n drives segment s[n]; entries are unique and never all-off.
  localparam seg_t SEG_TABLE [0:LETTER_COUNT-1] = '{
    14'h00F7, // A
    14'h128F, // B
    14'h0039, // C
    14'h120F, // D
    14'h00F9, // E
    14'h0071, // F
    14'h00BD, // G
    14'h00F6, // H
    14'h1209, // I
    14'h001E, // J
    14'h2470, // K
    14'h0038, // L
    14'h0536, // M
    14'h2136, // N
    14'h003F, // O
    14'h00F3, // P
    14'h203F, // Q
    14'h20F3, // R
    14'h00ED, // S
    14'h1201, // T
    14'h003E, // U
    14'h0C30, // V
    14'h2836, // W
    14'h2D00, // X
    14'h1500, // Y
    14'h0C09  // Z
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SCAN,
    OUT
  } dec_state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              err;
  } result_t;

endpackage

// File: rtl/seg14_table_rom.sv
// Letter index to 14-segment pattern lookup; out-of-range indices read blank.
module seg14_table_rom
  import alpha14_pkg::*;
(
  input  logic [CODE_W-1:0] idx,
  output logic [SEG_W-1:0]  pattern
);

  always_comb begin
    pattern = '0;
    if (idx < CODE_W'(LETTER_COUNT)) begin
      pattern = SEG_TABLE[idx];
    end
  end

endmodule

// File: rtl/seg14_letter_decoder.sv
// Recovers the letter code from a stable 14-segment pattern by scanning the
// shared letter table one entry per cycle.
module seg14_letter_decoder
  import alpha14_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEG_W-1:0]  seg_i,
  input  logic              seg_valid_i,
  output logic              seg_ready_o,
  output logic [CODE_W-1:0] code_o,
  output logic              err_o,
  output logic              code_valid_o,
  input  logic              code_ready_i
);

  dec_state_e        state_q, state_d;
  logic [SEG_W-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  result_t           res_q, res_d;
  logic              ready_q;
  logic              valid_q;
  logic [SEG_W-1:0]  rom_pat;
  logic              accept_c;

  seg14_table_rom u_rom (
    .idx     (idx_q),
    .pattern (rom_pat)
  );

  // ready_q mirrors "state is IDLE or SETTLE", so this is the beat handshake.
  assign accept_c = seg_valid_i && ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          cap_d   = seg_i;
          cnt_d   = CNT_W'(1);
          idx_d   = '0;
          state_d = (STABLE_CYCLES == 1) ? SCAN : SETTLE;
        end
      end
      SETTLE: begin
        // Gaps hold the count; a differing beat restarts it on the new pattern.
        if (accept_c) begin
          if (seg_i == cap_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(STABLE_CYCLES)) begin
              if (cap_q == '0) begin
                res_d.code = CODE_BLANK;
                res_d.err  = 1'b0;
                state_d    = OUT;
              end else begin
                idx_d   = '0;
                state_d = SCAN;
              end
            end
          end else begin
            cap_d = seg_i;
            cnt_d = CNT_W'(1);
          end
        end
      end
      SCAN: begin
        if (rom_pat == cap_q) begin
          res_d.code = idx_q;
          res_d.err  = 1'b0;
          state_d    = OUT;
        end else if (idx_q == CODE_W'(LETTER_COUNT - 1)) begin
          res_d.code = CODE_BLANK;
          res_d.err  = 1'b1;
          state_d    = OUT;
        end else begin
          idx_d = idx_q + CODE_W'(1);
        end
      end
      OUT: begin
        if (code_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ready_q <= (state_d == IDLE) || (state_d == SETTLE);
      valid_q <= (state_d == OUT);
    end
  end

  assign seg_ready_o  = ready_q;
  assign code_valid_o = valid_q;
  assign code_o       = res_q.code;
  assign err_o        = res_q.err;

endmodule

// File: tb/tb_seg14_letter_decoder.sv
// Self-checking bench for seg14_letter_decoder with STABLE_CYCLES=4.
module tb_seg14_letter_decoder;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] seg_i;
  logic        seg_valid_i;
  logic        seg_ready_o;
  logic [4:0]  code_o;
  logic        err_o;
  logic        code_valid_o;
  logic        code_ready_i;

  int total = 0;
  int bad   = 0;

  // Independent copy of the alphabet font used as the reference.
  logic [13:0] letters [26] = '{
    14'h00F7, 14'h128F, 14'h0039, 14'h120F, 14'h00F9, 14'h0071, 14'h00BD,
    14'h00F6, 14'h1209, 14'h001E, 14'h2470, 14'h0038, 14'h0536, 14'h2136,
    14'h003F, 14'h00F3, 14'h203F, 14'h20F3, 14'h00ED, 14'h1201, 14'h003E,
    14'h0C30, 14'h2836, 14'h2D00, 14'h1500, 14'h0C09
  };

  always #5 clk = ~clk;

  seg14_letter_decoder #(.STABLE_CYCLES(N), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_i        (seg_i),
    .seg_valid_i  (seg_valid_i),
    .seg_ready_o  (seg_ready_o),
    .code_o       (code_o),
    .err_o        (err_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result and cycles from "cycle after last stable beat" to valid.
  function automatic void ref_decode(input logic [13:0] p, output logic [4:0] c,
                                     output logic e, output int lat);
    c = 5'h1F; e = 1'b0; lat = 0;
    if (p == 14'h0) return;
    e = 1'b1; lat = 26;
    for (int k = 0; k < 26; k++) begin
      if (letters[k] == p) begin
        c = 5'(k); e = 1'b0; lat = k + 1;
        break;
      end
    end
  endfunction

  // Starts and ends at a falling edge; one beat (or gap) per cycle.
  task automatic beat(input logic [13:0] p, input logic v);
    if (v) check("beat_ready", 32'(seg_ready_o), 32'd1);
    seg_i       = p;
    seg_valid_i = v;
    @(negedge clk);
  endtask

  task automatic beats(input logic [13:0] p, input int n);
    for (int i = 0; i < n; i++) beat(p, 1'b1);
  endtask

  // Called in the cycle after the last stable beat; checks result and handshake.
  task automatic run_result(input logic [13:0] p, input int hold, input string tag);
    logic [4:0] ec;
    logic       ee;
    int         el;
    int         lat;
    ref_decode(p, ec, ee, el);
    lat = 0;
    while (code_valid_o !== 1'b1 && lat < 60) begin
      seg_valid_i = 1'($urandom_range(0, 1));
      seg_i       = 14'($urandom);
      @(negedge clk);
      lat++;
    end
    seg_valid_i = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_code"}, 32'(code_o), 32'(ec));
    check({tag, "_err"}, 32'(err_o), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      code_ready_i = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(code_valid_o), 32'd1);
      check({tag, "_hold_code"}, 32'(code_o), 32'(ec));
      check({tag, "_hold_ready"}, 32'(seg_ready_o), 32'd0);
    end
    code_ready_i = 1'b1;
    @(negedge clk);
    code_ready_i = 1'b0;
    check({tag, "_post_valid"}, 32'(code_valid_o), 32'd0);
    check({tag, "_post_ready"}, 32'(seg_ready_o), 32'd1);
  endtask

  initial begin
    logic [13:0] p, q;
    int          kind;
    rst_n        = 1'b0;
    seg_i        = '0;
    seg_valid_i  = 1'b0;
    code_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_code", 32'(code_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_valid", 32'(code_valid_o), 32'd0);
    check("rst_ready", 32'(seg_ready_o), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Letter A: valid at t+N+1.
    beats(letters[0], N);
    run_result(letters[0], 0, "dir_A");
    // Letter Z with a long downstream stall.
    beats(letters[25], N);
    run_result(letters[25], 10, "dir_Z");
    // Pattern absent from the table.
    beats(14'h3FFF, N);
    run_result(14'h3FFF, 1, "dir_miss");
    // Blank display skips the scan.
    beats(14'h0000, N);
    run_result(14'h0000, 1, "dir_blank");
    // Change restarts the count; gaps hold it.
    beats(letters[2], 3);
    beat(letters[7], 1'b1);
    beat(letters[7], 1'b0);
    beat(letters[7], 1'b1);
    beat(14'h1234, 1'b0);
    beat(letters[7], 1'b1);
    beat(letters[7], 1'b1);
    run_result(letters[7], 0, "dir_gap");

    // Reset in the middle of a scan.
    beats(letters[9], N);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(code_valid_o), 32'd0);
    check("midrst_ready", 32'(seg_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beats(letters[4], N);
    run_result(letters[4], 0, "post_rst_E");

    // Randomized patterns, prefixes, gaps and stalls.
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 5));
      if (kind <= 3)      p = letters[$urandom_range(0, 25)];
      else if (kind == 4) p = 14'($urandom);
      else                p = 14'h0;
      if ($urandom_range(0, 1) == 1) begin
        q = p ^ 14'($urandom_range(1, 16383));
        beats(q, int'($urandom_range(1, N - 1)));
      end
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) beat(14'($urandom), 1'b0);
        beat(p, 1'b1);
      end
      run_result(p, int'($urandom_range(0, 3)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
